alu_resp_unit: RTL
==================

ALU_RESP_UNIT -- requirements
Module: alu_resp_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 2, result buffer entries (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  operation request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port a  input  32  operand A.
REQ-007 SHALL have port b  input  32  operand B.
REQ-008 SHALL have port sel  input  2  opcode.
REQ-009 SHALL have port rsp_valid  output  1  head result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes head result.
REQ-011 SHALL have port rsp_out  output  32  head result.
REQ-012 SHALL have port op_count  output  8  number of accepted requests, modulo 256.

Function
REQ-013 SHALL treat a request as accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-014 SHALL treat a response as popped on a rising edge where rsp_valid=1 and rsp_ready=1.
REQ-015 SHALL compute the result from a, b and sel as follows: 00 gives a+b, 01 gives a-b, 10 gives a AND b, 11 gives a OR b.
REQ-016 SHALL compute the result modulo 2^32, with the carry/borrow discarded.
REQ-017 SHALL write the accepted result into a FIFO of DEPTH entries in the accepting cycle, preserving order.
REQ-018 SHALL provide a latency of 1 cycle: a request accepted at edge N into an empty FIFO gives rsp_valid=1 after edge N.
REQ-019 SHALL drive req_ready=1 only when the FIFO count is less than DEPTH.
REQ-020 SHALL NOT let a same-cycle pop raise req_ready while the FIFO is full.
REQ-021 SHALL drive rsp_valid=1 exactly when the FIFO count is greater than 0.
REQ-022 SHALL drive rsp_out from the FIFO head at all times.
REQ-023 SHALL hold rsp_out stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL, on a simultaneous accept and pop, leave the count unchanged and advance both pointers.
REQ-025 SHALL ignore rsp_ready while the FIFO is empty (no underflow).
REQ-026 SHALL ignore req_valid while the FIFO is full (no overflow, no count change).
REQ-027 SHALL use read/write pointers that wrap from DEPTH-1 to 0.
REQ-028 SHALL increment op_count by 1 on each accept, wrapping from 255 to 0.
REQ-029 SHALL drive req_ready combinationally from the count only, with no dependence on req_valid.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force count=0, pointers=0, op_count=0, rsp_valid=0 and req_ready=0.
REQ-031 SHALL set rsp_out=32'h0000_0000 in reset, with buffer contents cleared.
REQ-032 SHALL drive req_ready=1 on the first rising edge after rst_n is released.
REQ-033 SHALL discard all buffered results and produce no rsp_valid glitch when reset is asserted mid-operation.

Configuration
REQ-034 SHALL, when macro ALU_RESP_FLAGS_EN is defined, add outputs rsp_zero (1 bit, head result == 0) and rsp_carry (1 bit, carry-out of add or borrow of sub, 0 for AND/OR), both stored per FIFO entry and reset to 0.
REQ-035 SHALL, when ALU_RESP_FLAGS_EN is undefined, have neither port, and all other behaviour SHALL be identical.

Verification
REQ-036 SHALL cover an add: a=32'h0000_FFFF, b=32'hFFFF_0000, sel=00, accepted -> next cycle rsp_valid=1, rsp_out=32'hFFFF_FFFF, op_count=1.
REQ-037 SHALL cover a subtract: a=32'hFFFF_5828, b=32'hFFFF_0828, sel=01 -> rsp_out=32'h0000_5000; with flags, rsp_carry=0 and rsp_zero=0.
REQ-038 SHALL cover backpressure: rsp_ready=0 with DEPTH=2 and requests AND(32'h0A0A_0A0A, 32'h0000_FFFF) then OR(32'hF0F0_F0F0, 0) -> req_ready=0 after the 2nd accept; a 3rd req_valid is ignored; releasing rsp_ready yields 32'h0000_0A0A then 32'hF0F0_F0F0 in order.
REQ-039 SHALL cover simultaneous events: count=1 with accept and pop in the same cycle -> count stays 1 and the new result appears next.
REQ-040 SHALL cover wrap-around: 256 accepts -> op_count returns to 0; an add of 32'hFFFF_FFFF+1 -> rsp_out=0 (with flags, rsp_zero=1 and rsp_carry=1).
REQ-041 SHALL cover reset mid-operation: rst_n pulled low with 2 entries buffered -> rsp_valid=0, req_ready=0 and op_count=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/alu_resp_unit.sv
// ALU with a DEPTH-entry in-order result FIFO, 1-cycle latency and an accepted-request counter.
// Optional per-entry zero/carry flags are enabled by defining ALU_RESP_FLAGS_EN.
module alu_resp_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_out,
`ifdef ALU_RESP_FLAGS_EN
  output logic        rsp_zero,
  output logic        rsp_carry,
`endif
  output logic [7:0]  op_count
);

  localparam int PW = (DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    op_count_q, op_count_d;
  logic          init_q, init_d;
  logic          accept, pop;
  logic [31:0]   result;
  logic          carry;

`ifdef ALU_RESP_FLAGS_EN
  logic zero_q [DEPTH];
  logic zero_d [DEPTH];
  logic carry_q [DEPTH];
  logic carry_d [DEPTH];
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Bit 32 of the widened add/sub is the carry-out or the borrow.
  always_comb begin
    carry  = 1'b0;
    result = '0;
    unique case (sel)
      2'b00:   {carry, result} = {1'b0, a} + {1'b0, b};
      2'b01:   {carry, result} = {1'b0, a} - {1'b0, b};
      2'b10:   result = a & b;
      default: result = a | b;
    endcase
  end

  // init_q keeps ready low until the first edge after reset release.
  assign req_ready = init_q && (count_q < CW'(DEPTH));
  assign rsp_valid = (count_q != '0);
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_out   = mem_q[rd_ptr_q];
  assign op_count  = op_count_q;
`ifdef ALU_RESP_FLAGS_EN
  assign rsp_zero  = zero_q[rd_ptr_q];
  assign rsp_carry = carry_q[rd_ptr_q];
`endif

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;
    init_d     = 1'b1;
`ifdef ALU_RESP_FLAGS_EN
    zero_d     = zero_q;
    carry_d    = carry_q;
`endif
    if (accept) begin
      mem_d[wr_ptr_q] = result;
`ifdef ALU_RESP_FLAGS_EN
      zero_d[wr_ptr_q]  = (result == '0);
      carry_d[wr_ptr_q] = carry;
`endif
      wr_ptr_d   = ptr_next(wr_ptr_q);
      op_count_d = op_count_q + 8'd1;
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    unique case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef ALU_RESP_FLAGS_EN
        zero_q[i]  <= 1'b0;
        carry_q[i] <= 1'b0;
`endif
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_count_q <= '0;
      init_q     <= 1'b0;
    end else begin
      mem_q      <= mem_d;
`ifdef ALU_RESP_FLAGS_EN
      zero_q     <= zero_d;
      carry_q    <= carry_d;
`endif
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
      init_q     <= init_d;
    end
  end

endmodule
